// File: rtl/coeff_loader_pkg.sv
// Shared definitions for the coefficient loading path.
// Holds the default coefficient count and width and the loader FSM state
// type, so that the coefficient store and the filter can size themselves
// consistently with the loader.
package coeff_loader_pkg;

  localparam int unsigned CL_N_COEFF_DEF = 16;
  localparam int unsigned CL_W_DEF       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_CHECK = 2'b10
  } cl_state_e;

endpackage

// File: rtl/coeff_loader.sv
// coeff_loader
// Receives a byte stream of N_COEFF two's-complement coefficients followed
// by one checksum byte and writes the coefficients into an external store.
// The set is accepted when the modulo-2^W sum of all coefficients plus the
// checksum byte is zero.
//
// Ports
//   clka        in   clock, all state changes on its rising edge
//   rsta_n      in   asynchronous active-low reset
//   load_start  in   one-cycle request to begin a load (honoured in IDLE)
//   abort       in   one-cycle request to cancel a load in progress
//   s_valid     in   input stream valid
//   s_data      in   input stream data (W bits)
//   s_ready     out  loader accepts s_data this cycle
//   wr_en       out  coefficient store write strobe
//   wr_addr     out  coefficient store write address (AW bits)
//   wr_data     out  coefficient store write data (W bits)
//   busy        out  high whenever the FSM is not in IDLE
//   done        out  one-cycle pulse: load finished with good checksum
//   err         out  one-cycle pulse: load finished with bad checksum
//   coeff_valid out  store holds a complete, checksum-verified set
module coeff_loader
  import coeff_loader_pkg::*;
#(
  parameter int unsigned N_COEFF = CL_N_COEFF_DEF,
  parameter int unsigned W       = CL_W_DEF,
  parameter int unsigned AW      = 4
) (
  input  logic          clka,
  input  logic          rsta_n,
  input  logic          load_start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [W-1:0]  s_data,
  output logic          s_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          coeff_valid
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_COEFF - 1);

  cl_state_e     r_state;
  logic [AW-1:0] r_count;
  logic [W-1:0]  r_sum;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [W-1:0]  r_wr_data;
  logic          r_done;
  logic          r_err;
  logic          r_coeff_valid;

  logic          w_ready;
  logic          w_xfer;
  logic [W-1:0]  w_sum_next;

  // Ready depends on state only, so an abort drops it on the following cycle.
  assign w_ready    = (r_state != ST_IDLE);
  assign w_xfer     = s_valid & w_ready;
  assign w_sum_next = r_sum + s_data;

  // Store write port: a coefficient accepted in LOAD is written one cycle
  // later. This is independent of abort, so a transfer that coincides with
  // an abort still lands in the store.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_xfer && (r_state == ST_LOAD)) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_count;
        r_wr_data <= s_data;
      end
    end
  end

  // Control FSM, byte counter and checksum accumulator.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_sum         <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_coeff_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // abort has no effect here, so load_start wins when both are set
          if (load_start) begin
            r_state       <= ST_LOAD;
            r_count       <= '0;
            r_sum         <= '0;
            r_coeff_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_state       <= ST_IDLE;
            r_coeff_valid <= 1'b0;
          end else if (w_xfer) begin
            r_sum   <= w_sum_next;
            r_count <= r_count + AW'(1);
            if (r_count == LAST_IDX) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (abort) begin
            r_state       <= ST_IDLE;
            r_coeff_valid <= 1'b0;
          end else if (w_xfer) begin
            r_state <= ST_IDLE;
            if (w_sum_next == '0) begin
              r_done        <= 1'b1;
              r_coeff_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready     = w_ready;
  assign busy        = w_ready;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign done        = r_done;
  assign err         = r_err;
  assign coeff_valid = r_coeff_valid;

endmodule
